// File: rtl/stall_ctrl_multi_if.sv
// Bundle of stall request inputs and pipeline control outputs for stall_ctrl_multi.
// The master side drives hazard requests; the slave side is the stall controller.
interface stall_ctrl_multi_if #(
  parameter int CNT_W   = 3,
  parameter int NUM_SRC = 2,
  parameter int PERF_W  = 16
) ();

  logic [NUM_SRC*CNT_W-1:0] stall_cnt;
  logic                     mem_busy;
  logic                     flush;
  logic                     pause_pc;
  logic                     hold_ifid;
  logic                     bubble;
  logic                     busy;
  logic [CNT_W-1:0]         rem_cnt;
  logic                     err;
  logic [PERF_W-1:0]        stall_cyc;

  modport master (
    output stall_cnt, mem_busy, flush,
    input  pause_pc, hold_ifid, bubble, busy, rem_cnt, err, stall_cyc
  );

  modport slave (
    input  stall_cnt, mem_busy, flush,
    output pause_pc, hold_ifid, bubble, busy, rem_cnt, err, stall_cyc
  );

endinterface

// File: rtl/stall_ctrl_multi.sv
// Pipeline stall controller: merges multi-cycle stall requests into one countdown,
// with memory-busy hold, flush override, sticky over-range error and a perf counter.
module stall_ctrl_multi #(
  parameter int CNT_W     = 3,
  parameter int MAX_STALL = 6,
  parameter int NUM_SRC   = 2,
  parameter int PERF_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  stall_ctrl_multi_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STALL);

  typedef enum logic [1:0] {IDLE, STALL, HOLD} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  rem, rem_nxt;
  logic [CNT_W-1:0]  field, clipped, n_req, merged, load;
  logic              over_range;
  logic              pause;
  logic              err_q;
  logic [PERF_W-1:0] stall_cyc_q;

  // Each source is clipped to MAX_STALL before taking the max, so loads never exceed it.
  always_comb begin
    n_req      = '0;
    over_range = 1'b0;
    field      = '0;
    clipped    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      field = bus.stall_cnt[i*CNT_W +: CNT_W];
      if (field > MAX_C) begin
        over_range = 1'b1;
        clipped    = MAX_C;
      end else begin
        clipped = field;
      end
      if (clipped > n_req) n_req = clipped;
    end
  end

  assign merged = (rem > n_req) ? rem : n_req;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    pause     = 1'b0;
    load      = (state == IDLE) ? n_req : merged;
    if (bus.flush) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
    end else if (bus.mem_busy) begin
      pause     = 1'b1;
      state_nxt = HOLD;
      rem_nxt   = merged;
    end else begin
      // IDLE, STALL and a released HOLD all count down from the larger pending value.
      pause     = (load != '0);
      rem_nxt   = (load != '0) ? load - 1'b1 : '0;
      state_nxt = (rem_nxt != '0) ? STALL : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      err_q       <= 1'b0;
      stall_cyc_q <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      err_q <= err_q | over_range;
      if (pause && (stall_cyc_q != {PERF_W{1'b1}}))
        stall_cyc_q <= stall_cyc_q + 1'b1;
    end
  end

  assign bus.pause_pc  = pause & ~rst;
  assign bus.hold_ifid = pause & ~rst;
  assign bus.bubble    = (pause | bus.flush) & ~rst;
  assign bus.busy      = (state != IDLE);
  assign bus.rem_cnt   = rem;
  assign bus.err       = err_q;
  assign bus.stall_cyc = stall_cyc_q;

endmodule

// File: tb/tb_stall_ctrl_multi.sv
// Self-checking bench for stall_ctrl_multi: table of per-cycle vectors checked through a
// scoreboard queue, plus hand sequences for reset behaviour and the perf counter.
module tb_stall_ctrl_multi;

  localparam int CNT_W   = 3;
  localparam int NUM_SRC = 2;
  localparam int PERF_W  = 5;
  localparam int SAT     = (1 << PERF_W) - 1;

  logic clk;
  logic rst;

  stall_ctrl_multi_if #(.CNT_W(CNT_W), .NUM_SRC(NUM_SRC), .PERF_W(PERF_W)) bus ();

  stall_ctrl_multi #(
    .CNT_W(CNT_W), .MAX_STALL(6), .NUM_SRC(NUM_SRC), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s0;
    logic [2:0] s1;
    logic       mb;
    logic       fl;
    logic       pause;
    logic       bubble;
    logic       busy;
    logic [2:0] rem;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cyc = 0;

  task automatic addVec(input logic [2:0] s0, input logic [2:0] s1, input logic mb,
                        input logic fl, input logic p, input logic b, input logic bz,
                        input logic [2:0] r, input logic e);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.mb = mb; v.fl = fl;
    v.pause = p; v.bubble = b; v.busy = bz; v.rem = r; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue what the DUT should show.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    bus.stall_cnt = {v.s1, v.s0};
    bus.mem_busy  = v.mb;
    bus.flush     = v.fl;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      checkVal($sformatf("v%0d scoreboard_empty", idx), 0, 1);
    end else begin
      e = sb.pop_front();
      checkVal($sformatf("v%0d pause_pc", idx), int'(bus.pause_pc), int'(e.pause));
      checkVal($sformatf("v%0d hold_ifid", idx), int'(bus.hold_ifid), int'(e.pause));
      checkVal($sformatf("v%0d bubble", idx), int'(bus.bubble), int'(e.bubble));
      checkVal($sformatf("v%0d busy", idx), int'(bus.busy), int'(e.busy));
      checkVal($sformatf("v%0d rem_cnt", idx), int'(bus.rem_cnt), int'(e.rem));
      checkVal($sformatf("v%0d err", idx), int'(bus.err), int'(e.err));
      checkVal($sformatf("v%0d stall_cyc", idx), int'(bus.stall_cyc), exp_cyc);
      if (e.pause) exp_cyc = (exp_cyc == SAT) ? SAT : exp_cyc + 1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " pause_pc"}, int'(bus.pause_pc), 0);
    checkVal({tag, " hold_ifid"}, int'(bus.hold_ifid), 0);
    checkVal({tag, " bubble"}, int'(bus.bubble), 0);
    checkVal({tag, " busy"}, int'(bus.busy), 0);
    checkVal({tag, " rem_cnt"}, int'(bus.rem_cnt), 0);
    checkVal({tag, " err"}, int'(bus.err), 0);
    checkVal({tag, " stall_cyc"}, int'(bus.stall_cyc), 0);
  endtask

  initial begin
    vec_t v;

    // s0 s1 mb fl | pause bubble busy rem err
    // Lone request of 3
    addVec(3, 0, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 2, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 4 then shorter 2: no extension
    addVec(4, 0, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 2, 0, 0, 1, 1, 1, 3, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 2, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 4 then longer 5: extended to 6 total
    addVec(4, 0, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 5, 0, 0, 1, 1, 1, 3, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 4, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 3, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 2, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Simultaneous 2 and 5: max, not sum
    addVec(2, 5, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 4, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 3, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 2, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 4-cycle stall frozen by 3 cycles of mem_busy
    addVec(4, 0, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 1, 0, 1, 1, 1, 3, 0);
    addVec(0, 0, 1, 0, 1, 1, 1, 3, 0);
    addVec(0, 0, 1, 0, 1, 1, 1, 3, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 3, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 2, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Flush in 2nd cycle of a 5-cycle stall
    addVec(5, 0, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 1, 1, 4, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Flush together with mem_busy
    addVec(5, 0, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 1, 1, 0, 1, 1, 4, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Flush discards a same-cycle request
    addVec(3, 0, 0, 1, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // mem_busy alone, then release with nothing owed
    addVec(0, 0, 1, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Request of 1
    addVec(1, 0, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Over-range 7: clipped to 6, sticky err; perf counter saturates here
    addVec(7, 0, 0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 1, 1, 5, 1);
    addVec(0, 0, 0, 0, 1, 1, 1, 4, 1);
    addVec(0, 0, 0, 0, 1, 1, 1, 3, 1);
    addVec(0, 0, 0, 0, 1, 1, 1, 2, 1);
    addVec(0, 0, 0, 0, 1, 1, 1, 1, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset held with a pending request: everything must read 0
    rst           = 1'b1;
    bus.stall_cnt = 6'o03;
    bus.mem_busy  = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.stall_cnt = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end
    checkVal("sb_drained", sb.size(), 0);

    // Async reset in the middle of a stall drops outputs immediately
    v.s0 = 4; v.s1 = 0; v.mb = 0; v.fl = 0;
    v.pause = 1; v.bubble = 1; v.busy = 0; v.rem = 0; v.err = 1;
    applyStimulus(v);
    checkOutput(100);
    @(posedge clk);
    #1;
    bus.stall_cnt = 6'o03;
    bus.flush     = 1'b0;
    checkVal("pre_rst busy", int'(bus.busy), 1);
    checkVal("pre_rst rem_cnt", int'(bus.rem_cnt), 3);
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.stall_cnt = '0;
    exp_cyc = 0;

    v.s0 = 0; v.pause = 0; v.bubble = 0; v.busy = 0; v.rem = 0; v.err = 0;
    applyStimulus(v);
    checkOutput(101);
    v.s0 = 2; v.pause = 1; v.bubble = 1;
    applyStimulus(v);
    checkOutput(102);
    v.s0 = 0; v.busy = 1; v.rem = 1;
    applyStimulus(v);
    checkOutput(103);
    v.busy = 0; v.rem = 0; v.pause = 0; v.bubble = 0;
    applyStimulus(v);
    checkOutput(104);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
